// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared types and constants for the APB master controller.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_WIDTH = 32;

    localparam logic SLV1 = 1'b0;
    localparam logic SLV2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_ctrl_if
// Brief    : Request/response port plus two-slave APB bus of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_ctrl_if
    import apb_pkg::*;
#(
    parameter int WIDTH = APB_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             PSEL1;
    logic             PSEL2;
    logic             PENABLE;
    logic             PWRITE;
    logic [WIDTH-1:0] paddr;
    logic [WIDTH-1:0] pwdata;
    logic             PREADY1;
    logic             PREADY2;
    logic [WIDTH-1:0] prdata1;
    logic [WIDTH-1:0] prdata2;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PREADY1, PREADY2, prdata1, prdata2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PREADY1, PREADY2, prdata1, prdata2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, paddr, pwdata
    );

endinterface
`default_nettype wire

// File: rtl/apb_slave_decoder.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_decoder
// Brief    : Maps the slave index to PSEL lines and muxes PREADY/prdata back.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_decoder
    import apb_pkg::*;
#(
    parameter int WIDTH = APB_WIDTH
) (
    input  logic             sel,
    input  logic             pready1,
    input  logic             pready2,
    input  logic [WIDTH-1:0] prdata1,
    input  logic [WIDTH-1:0] prdata2,
    output logic             psel1,
    output logic             psel2,
    output logic             pready,
    output logic [WIDTH-1:0] prdata
);

    always_comb begin
        psel1  = (sel == SLV1);
        psel2  = (sel == SLV2);
        pready = (sel == SLV2) ? pready2 : pready1;
        prdata = (sel == SLV2) ? prdata2 : prdata1;
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_ctrl
// Brief    : Sequences single valid/ready requests onto a two-slave APB bus.
//            Optional ACCESS timeout abort enabled by macro APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int WIDTH          = APB_WIDTH,
    parameter int SEL_BIT        = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_master_ctrl_if.master  bus
);

    if (SEL_BIT < 0 || SEL_BIT >= WIDTH) begin : g_bad_sel_bit
        $error("SEL_BIT must index into the address");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [WIDTH-1:0] c_sel_mask = ~(WIDTH'(1) << SEL_BIT);

    apb_state_e       state;
    logic             slv;
    logic             dec_sel;
    logic             psel1_d;
    logic             psel2_d;
    logic             pready_sel;
    logic [WIDTH-1:0] prdata_sel;

    // Before acceptance the decoder looks at the incoming address; afterwards
    // it follows the latched index so only the selected slave is heard.
    assign dec_sel       = (state == IDLE) ? bus.req_addr[SEL_BIT] : slv;
    assign bus.req_ready = (state == IDLE);

    apb_slave_decoder #(
        .WIDTH   (WIDTH)
    ) u_decoder (
        .sel     (dec_sel),
        .pready1 (bus.PREADY1),
        .pready2 (bus.PREADY2),
        .prdata1 (bus.prdata1),
        .prdata2 (bus.prdata2),
        .psel1   (psel1_d),
        .psel2   (psel2_d),
        .pready  (pready_sel),
        .prdata  (prdata_sel)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            slv           <= SLV1;
            bus.PSEL1     <= 1'b0;
            bus.PSEL2     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
                    err_q         <= 1'b0;
`endif
                    if (bus.req_valid) begin
                        slv         <= bus.req_addr[SEL_BIT];
                        bus.PSEL1   <= psel1_d;
                        bus.PSEL2   <= psel2_d;
                        bus.PENABLE <= 1'b0;
                        bus.PWRITE  <= bus.req_write;
                        bus.paddr   <= bus.req_addr & c_sel_mask;
                        bus.pwdata  <= bus.req_wdata;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                ACCESS: begin
                    // A ready arriving in the expiry cycle still completes normally.
                    if (pready_sel) begin
                        if (!bus.PWRITE) begin
                            bus.rsp_rdata <= prdata_sel;
                        end
                        bus.PSEL1     <= 1'b0;
                        bus.PSEL2     <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.PSEL1     <= 1'b0;
                        bus.PSEL2     <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        err_q         <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_ctrl
// Brief    : Randomised self-checking bench with two memory slaves and a
//            transaction-level reference model (APB_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_ctrl_if #(.WIDTH(32)) bus ();

    apb_master_ctrl #(
        .WIDTH          (32),
        .SEL_BIT        (6),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int s, input int i);
        return 32'h1000_0000 * (s + 1) + i * 32'h0001_0203;
    endfunction

    // ---------------- slave models (64-word memories) ----------------
    logic [31:0] smem [2][64];
    logic [1:0]  srdy;
    logic [31:0] srd [2];
    int          scnt [2];
    int          waits_cfg = 0;
    bit          stall     = 1'b0;
    bit          noise_en  = 1'b0;
    logic [1:0]  noise     = 2'b00;
    logic        psel_v [2];

    assign psel_v[0] = bus.PSEL1;
    assign psel_v[1] = bus.PSEL2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                srdy[s] <= 1'b0;
                scnt[s] <= 0;
                srd[s]  <= 32'h0;
                for (int i = 0; i < 64; i++) smem[s][i] <= init_val(s, i);
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (psel_v[s] && bus.PENABLE && !srdy[s] && !stall) begin
                    if (scnt[s] == waits_cfg) begin
                        srdy[s] <= 1'b1;
                        scnt[s] <= 0;
                        if (bus.PWRITE) smem[s][bus.paddr[5:0]] <= bus.pwdata;
                        else            srd[s] <= smem[s][bus.paddr[5:0]];
                    end else begin
                        scnt[s] <= scnt[s] + 1;
                    end
                end else begin
                    srdy[s] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) noise <= noise_en ? 2'($urandom) : 2'b00;

    // Unselected slave may chatter on its PREADY; the controller must not hear it.
    assign bus.PREADY1 = srdy[0] | (noise[0] & ~bus.PSEL1);
    assign bus.PREADY2 = srdy[1] | (noise[1] & ~bus.PSEL2);
    assign bus.prdata1 = srd[0];
    assign bus.prdata2 = srd[1];

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [2][64];
    logic [31:0] last_rdata;

    task automatic ref_reset();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) ref_mem[s][i] = init_val(s, i);
        last_rdata = 32'h0;
    endtask

    // ---------------- protocol monitor ----------------
    logic        p_en  = 1'b0;
    logic        p_sel = 1'b0;
    logic [65:0] p_snap = '0;
    logic [65:0] snap;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_en  <= 1'b0;
            p_sel <= 1'b0;
        end else begin
            snap = {bus.paddr, bus.pwdata, bus.PSEL1, bus.PSEL2};
            chk("psel_onehot", 32'(bus.PSEL1 & bus.PSEL2), 32'd0);
            chk("ready_vs_busy", 32'(bus.req_ready), 32'(!(bus.PSEL1 | bus.PSEL2)));
            if (bus.PENABLE) chk("en_needs_sel", 32'(bus.PSEL1 | bus.PSEL2), 32'd1);
            if (bus.PENABLE && !p_en) chk("setup_before_en", 32'(p_sel && !p_en), 32'd1);
            if (bus.PENABLE && p_en) chk("access_stable", 32'(snap == p_snap), 32'd1);
            p_en   <= bus.PENABLE;
            p_sel  <= bus.PSEL1 | bus.PSEL2;
            p_snap <= snap;
        end
    end

    // One transfer from request to response; ends on the response sample.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit hold, input bit stall_mode);
        int          s;
        int          idx;
        int          n;
        int          exp_lat;
        logic [31:0] exp_pa;
        s       = int'(addr[6]);
        idx     = int'(addr[5:0]);
        exp_pa  = addr & ~32'h40;
        exp_lat = stall_mode ? (2 + TO) : (4 + waits);
        waits_cfg     = waits;
        stall         = stall_mode;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
        @(negedge clk);
        chk("setup_psel1", 32'(bus.PSEL1), 32'(s == 0));
        chk("setup_psel2", 32'(bus.PSEL2), 32'(s == 1));
        chk("setup_en", 32'(bus.PENABLE), 32'd0);
        chk("paddr", bus.paddr, exp_pa);
        chk("pwrite", 32'(bus.PWRITE), 32'(wr));
        if (wr) chk("pwdata", bus.pwdata, wdata);
        chk("no_rsp_setup", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("access_en", 32'(bus.PENABLE), 32'd1);
        n = 2;
        while (!bus.rsp_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        if (stall_mode) begin
            chk("to_err", 32'(bus.rsp_err), 32'd1);
            chk("to_rdata", bus.rsp_rdata, last_rdata);
        end else begin
            chk("rsp_err", 32'(bus.rsp_err), 32'd0);
            if (wr) begin
                ref_mem[s][idx] = wdata;
                chk("wr_rdata_kept", bus.rsp_rdata, last_rdata);
            end else begin
                last_rdata = ref_mem[s][idx];
                chk("rd_data", bus.rsp_rdata, last_rdata);
            end
        end
        chk("done_psel", 32'(bus.PSEL1 | bus.PSEL2), 32'd0);
        chk("done_en", 32'(bus.PENABLE), 32'd0);
        chk("done_ready", 32'(bus.req_ready), 32'd1);
        stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        ref_reset();

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_psel", 32'({bus.PSEL1, bus.PSEL2}), 32'd0);
        chk("rst_en_wr", 32'({bus.PENABLE, bus.PWRITE}), 32'd0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_xfer(1'b1, 32'h05, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        chk("slave1_mem5", smem[0][5], 32'hDEAD_BEEF);
        do_xfer(1'b1, 32'h45, 32'h1234_5678, 0, 1'b0, 1'b0);
        do_xfer(1'b0, 32'h45, 32'h0, 0, 1'b0, 1'b0);

        do_xfer(1'b1, 32'h10, 32'hA1A1_0001, 0, 1'b1, 1'b0);
        do_xfer(1'b0, 32'h50, 32'h0, 0, 1'b1, 1'b0);
        do_xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0);

        do_xfer(1'b1, 32'h47, 32'hAAAA_5555, 3, 1'b0, 1'b0);
        do_xfer(1'b0, 32'h47, 32'h0, 3, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_pulse", 32'(bus.rsp_valid), 32'd0);

        // Reset in the middle of a stalled ACCESS.
        stall         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0A;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("stall_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("stall_in_access", 32'(bus.PENABLE), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_psel", 32'({bus.PSEL1, bus.PSEL2}), 32'd0);
        chk("arst_en", 32'(bus.PENABLE), 32'd0);
        chk("arst_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        ref_reset();
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

`ifdef APB_TIMEOUT_EN
        do_xfer(1'b0, 32'h45, 32'h0, 0, 1'b0, 1'b0);
        do_xfer(1'b0, 32'h03, 32'h0, 0, 1'b0, 1'b1);
        do_xfer(1'b1, 32'h44, 32'h0BAD_C0DE, TO - 2, 1'b0, 1'b0);
        do_xfer(1'b0, 32'h44, 32'h0, 0, 1'b0, 1'b0);
`endif

        noise_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            hold = 1'($urandom_range(0, 1));
            do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 5), hold, 1'b0);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.req_valid = 1'b0;
        noise_en      = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
